// File: rtl/phy_tx_pkg.sv
// phy_tx_pkg
// Constants and types shared by the phy_tx transmit path and the rx aligner.
//   BYTE_W     : byte width on the lane
//   SYM_COM    : idle / alignment symbol
//   SYM_SKP    : skip symbol
//   tx_state_e : serializer state (SYNC burst, then ACTIVE)
package phy_tx_pkg;

  localparam int         BYTE_W  = 8;
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/serializador_tx.sv
// serializador_tx
// Parallel-to-serial stage after the 2:1 lane mux. Shifts bytes out MSB-first,
// one bit per clk_8f cycle. After reset it sends SYNC_COUNT COM symbols, then
// accepts mux bytes; empty slots are filled with COM.
//
// Optional build macro: SKP_INSERT_EN
//   When defined, one SKP symbol replaces a slot after every SKP_PERIOD
//   non-SKP slots in ACTIVE; valid data is held back during that slot.
//
// Ports
//   clk_8f    in   bit clock (8x byte rate), rising edge
//   reset     in   synchronous, active-high
//   data_in   in   [7:0] byte from the mux
//   valid_in  in   data_in holds a real byte
//   data_out  out  serial bit, MSB of the shift register (registered)
//   byte_ack  out  combinational; data_in is consumed at this rising edge
//   active    out  registered; high once the SYNC burst is complete
//
// State  | meaning
// SYNC   | sending start-up COM burst, upstream data not accepted
// ACTIVE | forwarding mux bytes, COM on idle slots (terminal until reset)
module serializador_tx
  import phy_tx_pkg::*;
#(
  parameter int         SYNC_COUNT = 4,
  parameter logic [7:0] COM        = SYM_COM,
  parameter logic [7:0] SKP        = SYM_SKP,
  parameter int         SKP_PERIOD = 16
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              byte_ack,
  output logic              active
);

  localparam int SYNC_W = $clog2(SYNC_COUNT + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COUNT - 1);

  tx_state_e         state, state_nxt;
  logic [BYTE_W-1:0] shift_reg;
  logic [BYTE_W-1:0] next_byte;
  logic [2:0]        bit_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic              load;
  logic              skp_slot;
  logic              sync_done;

  assign load      = (bit_cnt == 3'd0);
  assign sync_done = (state == SYNC) && load && (sync_cnt == SYNC_LAST);
  assign data_out  = shift_reg[BYTE_W-1];

`ifdef SKP_INSERT_EN
  localparam int SKP_W = $clog2(SKP_PERIOD + 1);
  localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_PERIOD);

  logic [SKP_W-1:0] skp_cnt;

  assign skp_slot = (state == ACTIVE) && (skp_cnt == SKP_LAST);

  // Counts every ACTIVE slot that is not itself a SKP; the SKP slot restarts it.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      skp_cnt <= '0;
    end else if (state == ACTIVE && load) begin
      if (skp_slot) skp_cnt <= '0;
      else          skp_cnt <= skp_cnt + 1'b1;
    end
  end
`else
  localparam int unused_skp_period = SKP_PERIOD;

  assign skp_slot = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    next_byte = COM;
    byte_ack  = 1'b0;
    case (state)
      SYNC: begin
        if (sync_done) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (skp_slot) begin
          next_byte = SKP;
        end else if (load && valid_in && !reset) begin
          next_byte = data_in;
          byte_ack  = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state     <= SYNC;
      shift_reg <= '0;
      bit_cnt   <= 3'd0;
      sync_cnt  <= '0;
      active    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt + 3'd1;
      if (load) shift_reg <= next_byte;
      else      shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
      if (state == SYNC && load) sync_cnt <= sync_cnt + 1'b1;
      if (sync_done) active <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serializador_tx.sv
// tb_serializador_tx
// Scoreboard bench for serializador_tx: a cycle model decides the byte of each
// slot, pushes its bits to a queue, and each cycle the serial output is popped
// and compared. byte_ack and active are compared every cycle.
// Build with +define+SKP_INSERT_EN to exercise SKP insertion (period 2).
module tb_serializador_tx;

  localparam logic [7:0] TB_COM = 8'hBC;
  localparam logic [7:0] TB_SKP = 8'h1C;
  localparam int         TB_SYNC = 4;
`ifdef SKP_INSERT_EN
  localparam bit TB_SKP_EN = 1'b1;
  localparam int TB_SKP_P  = 2;
`else
  localparam bit TB_SKP_EN = 1'b0;
  localparam int TB_SKP_P  = 16;
`endif

  logic       clk_8f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       byte_ack;
  logic       active;

  serializador_tx #(
    .SYNC_COUNT (TB_SYNC),
    .SKP_PERIOD (TB_SKP_P)
  ) dut (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .byte_ack (byte_ack),
    .active   (active)
  );

  always #5 clk_8f = ~clk_8f;

  int n_checks = 0;
  int n_pass   = 0;

  logic       sb_bits[$];
  logic [7:0] prod[$];

  int m_cnt    = 0;
  int m_sync   = 0;
  int m_skp    = 0;
  bit m_active = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_inputs();
    valid_in = (prod.size() != 0);
    data_in  = (prod.size() != 0) ? prod[0] : 8'h00;
  endtask

  task automatic tick();
    logic       exp_ack;
    logic       skp_now;
    logic       exp_out;
    logic [7:0] b;
    @(negedge clk_8f);
    skp_now = TB_SKP_EN && m_active && (m_skp == TB_SKP_P);
    exp_ack = !reset && m_active && (m_cnt == 0) && valid_in && !skp_now;
    check_val("byte_ack", {31'd0, byte_ack}, {31'd0, exp_ack});
    @(posedge clk_8f);
    if (reset) begin
      sb_bits.delete();
      m_cnt = 0; m_sync = 0; m_skp = 0; m_active = 1'b0;
      exp_out = 1'b0;
    end else begin
      if (m_cnt == 0) begin
        if (!m_active) begin
          b = TB_COM;
          if (m_sync == TB_SYNC - 1) m_active = 1'b1;
          m_sync++;
        end else if (skp_now) begin
          b = TB_SKP;
          m_skp = 0;
        end else begin
          b = exp_ack ? data_in : TB_COM;
          m_skp++;
        end
        for (int i = 7; i >= 0; i--) sb_bits.push_back(b[i]);
      end
      m_cnt = (m_cnt + 1) % 8;
      exp_out = sb_bits.pop_front();
    end
    #1;
    check_val("data_out", {31'd0, data_out}, {31'd0, exp_out});
    check_val("active", {31'd0, active}, {31'd0, m_active});
    if (exp_ack) void'(prod.pop_front());
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // reset held 3 cycles, then a long idle run covering the SYNC burst
    run(3);
    reset = 1'b0;
    run(64);

    // single byte followed by COM once valid drops
    prod.push_back(8'hA5);
    drive_inputs();
    run(24);

    // back-to-back bytes
    prod.push_back(8'h3C);
    prod.push_back(8'hFF);
    drive_inputs();
    run(32);

    // reset in the middle of a byte while a byte is held upstream
    for (int i = 0; i < 8 && m_cnt != 4; i++) tick();
    prod.push_back(8'h5A);
    drive_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(48);

    // sustained traffic; exercises SKP insertion when enabled
    for (int i = 0; i < 8; i++) prod.push_back(8'(8'h11 * (i + 1)));
    drive_inputs();
    run(96);

    // random byte stream with random gaps
    for (int k = 0; k < 6; k++) begin
      prod.push_back(8'($urandom_range(0, 255)));
      drive_inputs();
      run(8 + $urandom_range(0, 16));
    end
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
